// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and helpers for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_LS   = 2'd2
   } owner_e;

   typedef struct packed {
      owner_e owner;
      logic   err;
   } inflight_t;

   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   localparam inflight_t INFLIGHT_IDLE = '{owner: OWN_NONE, err: 1'b0};

   function automatic logic is_word_aligned(input logic [1:0] lsb);
      return (lsb & WORD_ALIGN_MASK) == 2'b00;
   endfunction

   function automatic owner_e other_side(input owner_e side);
      return (side == OWN_IF) ? OWN_LS : OWN_IF;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed LS priority
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   if_valid,
   input  logic   ls_valid,
   input  owner_e ptr,
   output owner_e grant
);

   always_comb begin
      grant = OWN_NONE;
      if (if_valid && ls_valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         grant = (ptr == OWN_IF) ? OWN_IF : OWN_LS;
`else
         grant = OWN_LS;
`endif
      end else if (if_valid) begin
         grant = OWN_IF;
      end else if (ls_valid) begin
         grant = OWN_LS;
      end
   end

`ifndef MEM_ARB_ROUND_ROBIN_EN
   // Fixed priority never consults the pointer.
   logic unused_ptr;
   assign unused_ptr = ^ptr;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester read arbiter for one memory port; MEM_ARB_ROUND_ROBIN_EN enables round-robin
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_valid,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [DATA_W-1:0] if_rsp_data,
   output logic              if_rsp_err,
   input  logic              ls_req_valid,
   input  logic [ADDR_W-1:0] ls_req_addr,
   output logic              ls_req_ready,
   output logic              ls_rsp_valid,
   output logic [DATA_W-1:0] ls_rsp_data,
   output logic              ls_rsp_err,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_read_data,
   output logic [1:0]        grant_owner
);

   owner_e            ptr;
   owner_e            win;
   inflight_t         inflight_q;
   inflight_t         inflight_d;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] win_addr;
   logic              any_win;
   logic              win_aligned;

   // No grants while reset is held, so readies and the read strobe stay low.
   mem_arb_pick u_pick (
      .if_valid (if_req_valid && !reset),
      .ls_valid (ls_req_valid && !reset),
      .ptr      (ptr),
      .grant    (win)
   );

   always_comb begin
      any_win     = (win != OWN_NONE);
      win_addr    = (win == OWN_IF) ? if_req_addr : ls_req_addr;
      win_aligned = is_word_aligned(win_addr[1:0]);
      inflight_d  = INFLIGHT_IDLE;
      if (any_win) begin
         inflight_d.owner = win;
         inflight_d.err   = !win_aligned;
      end
   end

   assign if_req_ready    = (win == OWN_IF);
   assign ls_req_ready    = (win == OWN_LS);
   assign mem_read_enable = any_win && win_aligned;
   assign mem_address     = mem_read_enable ? win_addr : addr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q <= INFLIGHT_IDLE;
         addr_q     <= '0;
      end else begin
         inflight_q <= inflight_d;
         if (mem_read_enable) begin
            addr_q <= win_addr;
         end
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   owner_e ptr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= OWN_LS;
      end else if (any_win) begin
         ptr_q <= other_side(win);
      end
   end

   assign ptr = ptr_q;
`else
   assign ptr = OWN_LS;
`endif

   // Memory data arrives in the response cycle, so route it straight through.
   assign if_rsp_valid = (inflight_q.owner == OWN_IF);
   assign if_rsp_err   = if_rsp_valid && inflight_q.err;
   assign if_rsp_data  = (if_rsp_valid && !inflight_q.err) ? mem_read_data : '0;

   assign ls_rsp_valid = (inflight_q.owner == OWN_LS);
   assign ls_rsp_err   = ls_rsp_valid && inflight_q.err;
   assign ls_rsp_data  = (ls_rsp_valid && !inflight_q.err) ? mem_read_data : '0;

   assign grant_owner  = inflight_q.owner;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester read arbiter that shares the single `simple_memory` read port between the instruction-fetch path and the load path of `riscv_load_pipeline`. Each cycle it grants at most one request, drives the memory address and read enable, and routes the memory's one-cycle-later read data back to the requester that owns it. It also rejects misaligned word addresses with an error response instead of accessing memory.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `reset`, in, 1, asynchronous, active-high.
- `if_req_valid`, in, 1, fetch request valid.
- `if_req_addr`, in, ADDR_W, fetch byte address.
- `if_req_ready`, out, 1, fetch request accepted this cycle.
- `if_rsp_valid`, out, 1, fetch response valid (one-cycle pulse).
- `if_rsp_data`, out, DATA_W, fetch response data.
- `if_rsp_err`, out, 1, fetch response is a misalignment error.
- `ls_req_valid`, `ls_req_addr`, `ls_req_ready`, `ls_rsp_valid`, `ls_rsp_data`, `ls_rsp_err`: same roles for the load path.
- `mem_address`, out, ADDR_W, memory address.
- `mem_read_enable`, out, 1, memory read strobe.
- `mem_read_data`, in, DATA_W, memory data, valid one cycle after the address/enable cycle.
- `grant_owner`, out, 2, owner of the in-flight slot: 0 none, 1 IF, 2 LS.

## Operation
- **Accept:** a request is accepted when `*_req_valid && *_req_ready`. `*_req_ready` is combinational and is high only for that cycle's winner.
- **Arbitration:**
  - If only one requester is valid, it wins.
  - If both are valid, the priority rule decides (see Configuration).
- **Aligned win** (`addr[1:0]==0`):
  - `mem_address` = winner address and `mem_read_enable`=1 in the same cycle.
  - An in-flight register records `{owner, err=0}`.
- **Misaligned win:**
  - The request is still accepted.
  - `mem_read_enable` stays 0 and `mem_address` holds its last value.
  - The in-flight register records `{owner, err=1}`.
- **Response:**
  - In the cycle after acceptance, the recorded owner's `*_rsp_valid` is high for exactly one cycle.
  - `*_rsp_data` = `mem_read_data` when err=0, and 0 when err=1. `*_rsp_err` = err.
  - The other requester's `*_rsp_*` outputs are all 0.
- **Back-to-back:** a new grant may occur in the same cycle as the previous response, giving one access per cycle. Responses have no backpressure; requesters must accept them.
- **No request:** `mem_read_enable`=0 and no state changes, except that the in-flight register clears to none.

## Timing
- **Reset values:** all `*_req_ready`, `*_rsp_valid`, `*_rsp_err` and `mem_read_enable` are 0. `*_rsp_data`, `mem_address` and `grant_owner` are 0. The RR pointer is set to LS.
- **Latency:** accept cycle N, response cycle N+1. This is fixed and applies to errors too.
- **Combinational paths:** `mem_address`, `mem_read_enable` and `*_req_ready` are combinational from `*_req_valid`/`*_req_addr` and the pointer. Response outputs are combinational from the in-flight register and `mem_read_data`.
- **Reset mid-operation:** the in-flight access is dropped and no response is issued after reset deasserts.
- **Requester behaviour when not granted:** the requester must hold valid and addr stable until accepted. The arbiter does not latch pending requests.
- **Simultaneous events:** a response to requester X and a new grant to requester X in the same cycle is legal.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined:
  - On a conflict, the side named by the RR pointer wins.
  - After every accepted request, the pointer moves to the other side, so neither requester starves.
- Undefined:
  - Fixed priority, LS always wins on a conflict.
  - There is no pointer register.
  - IF can starve while LS streams requests.

## Structure
- **Package `mem_arb_pkg`:**
  - `typedef enum logic [1:0] {OWN_NONE=0, OWN_IF=1, OWN_LS=2} owner_e`.
  - `typedef struct packed {owner_e owner; logic err;} inflight_t`.
  - `WORD_ALIGN_MASK` = 2'b11.
- **Sub-module `mem_arb_pick`:** combinational winner select taking valids and pointer, returning the grant. It contains the `ifdef` for the priority mode.

## Test plan
Memory holds 0x0=DEADBEEF, 0x4=12345678, 0xC=FEDCBA98.
1. Only LS valid, addr 0x0 -> `ls_req_ready`=1 at cycle N; at N+1 `ls_rsp_valid`=1, data DEADBEEF, err 0; `if_rsp_valid`=0.
2. IF and LS both valid every cycle (IF 0x4, LS 0xC), with RR -> grants alternate LS, IF, LS, IF…; responses carry FEDCBA98 and 12345678 correctly routed. Without RR -> LS is granted every cycle and `if_req_ready` stays 0.
3. LS addr 0x6 -> accepted, `mem_read_enable`=0; next cycle `ls_rsp_valid`=1, err=1, data 0.
4. IF requests 0x0 then 0x4 on consecutive cycles -> two consecutive responses DEADBEEF, 12345678 with no bubble.
5. `reset` asserted the cycle after LS accepts 0xC -> no `ls_rsp_valid` after reset deasserts; all outputs 0; first post-reset conflict goes to LS.
